// File: rtl/DR1_LOGIC_ODDR.sv
// DDR output register: d0 is driven while clk is high, d1 while clk is low.
// Both inputs are captured on the rising edge; d1 is re-timed to the falling edge.
module DR1_LOGIC_ODDR (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    output logic q
);

    logic q0;
    logic q1;
    logic q1n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= 1'b0;
            q1 <= 1'b0;
        end else begin
            q0 <= d0;
            q1 <= d1;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) q1n <= 1'b0;
        else     q1n <= q1;
    end

    assign q = clk ? q0 : q1n;

endmodule

// File: rtl/lvds_tx_lanes_param.sv
// Multi-lane LVDS serialiser: pixel-rate word select and training FSM,
// toggle-based word-boundary recovery in the DDR bit domain and lock detection.
module lvds_tx_lanes_param #(
    parameter int LANES = 4,
    parameter int DATA_W = 10,
    parameter int MSB_FIRST = 1,
    parameter int TRAIN_LEN = 16,
    parameter logic [DATA_W-1:0] TRAIN_PAT =
        {{(DATA_W/2){1'b1}}, {(DATA_W/2){1'b0}}}
) (
    input  logic                    I_pixel_clk,
    input  logic                    I_serial_clk,
    input  logic                    I_rst,
    input  logic [LANES*DATA_W-1:0] I_data_in,
    input  logic [LANES-1:0]        I_lane_en,
    input  logic                    I_train_req,
    output logic [LANES-1:0]        O_serial_out,
    output logic                    O_train_active,
    output logic                    O_locked
);

    localparam int HALF = DATA_W / 2;
    localparam int CNT_W = $clog2(TRAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TRAIN_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        TRAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic train_active;
    logic toggle;
    logic [LANES*DATA_W-1:0] pix_word;
    logic [LANES*DATA_W-1:0] pix_word_nxt;
    logic lock_s1;
    logic lock_s2;
    logic locked;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (I_train_req) begin
                    state_nxt = TRAIN;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            TRAIN: begin
                if (I_train_req) begin
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix_word_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            if (state == TRAIN)
                pix_word_nxt[k*DATA_W +: DATA_W] = TRAIN_PAT;
            else if (I_lane_en[k])
                pix_word_nxt[k*DATA_W +: DATA_W] = I_data_in[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge I_pixel_clk or posedge I_rst) begin
        if (I_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            train_active <= 1'b0;
            toggle       <= 1'b0;
            pix_word     <= '0;
            lock_s1      <= 1'b0;
            lock_s2      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            train_active <= (state_nxt == TRAIN);
            toggle       <= ~toggle;
            pix_word     <= pix_word_nxt;
            lock_s1      <= locked;
            lock_s2      <= lock_s1;
        end
    end

    assign O_train_active = train_active;
    assign O_locked       = lock_s2;

    // Toggle edge, re-timed so the load lands mid-way through a stable pixel word.
    logic [2:0] sync;
    logic       boundary;
    logic [1:0] ld_pipe;
    logic       load_en;

    always_ff @(posedge I_serial_clk or posedge I_rst) begin
        if (I_rst) begin
            sync     <= '0;
            boundary <= 1'b0;
            ld_pipe  <= '0;
        end else begin
            sync     <= {sync[1:0], toggle};
            boundary <= sync[1] ^ sync[2];
            ld_pipe  <= {ld_pipe[0], boundary};
        end
    end

    assign load_en = ld_pipe[1];

    logic [3:0] lk_cnt;
    logic [1:0] good;

    always_ff @(posedge I_serial_clk or posedge I_rst) begin
        if (I_rst) begin
            lk_cnt <= '0;
            good   <= '0;
            locked <= 1'b0;
        end else if (load_en) begin
            lk_cnt <= '0;
            if (lk_cnt == 4'(HALF - 1)) begin
                if (good == 2'd3) locked <= 1'b1;
                else              good   <= good + 1'b1;
            end else begin
                good   <= '0;
                locked <= 1'b0;
            end
        end else if (lk_cnt == 4'hF) begin
            good   <= '0;
            locked <= 1'b0;
        end else begin
            lk_cnt <= lk_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] ld_word;
        logic [DATA_W-1:0] shifter;
        logic              d0;
        logic              d1;

        always_comb begin
            ld_word = '0;
            for (int i = 0; i < DATA_W; i++) begin
                if (MSB_FIRST != 0)
                    ld_word[i] = pix_word[k*DATA_W + i];
                else
                    ld_word[i] = pix_word[k*DATA_W + DATA_W - 1 - i];
            end
        end

        always_ff @(posedge I_serial_clk or posedge I_rst) begin
            if (I_rst) begin
                shifter <= '0;
                d0      <= 1'b0;
                d1      <= 1'b0;
            end else begin
                shifter <= load_en ? ld_word : (shifter << 2);
                d0      <= shifter[DATA_W-1];
                d1      <= shifter[DATA_W-2];
            end
        end

        DR1_LOGIC_ODDR u_oddr (
            .clk (I_serial_clk),
            .rst (I_rst),
            .d0  (d0),
            .d1  (d1),
            .q   (O_serial_out[k])
        );
    end

endmodule

// File: tb/tb_lvds_tx_lanes_param.sv
// Bench for lvds_tx_lanes_param: word-level model against both bit orders,
// plus directed lock, training, lane-enable and reset scenarios.
module tb_lvds_tx_lanes_param;

    logic        pclk = 1'b0;
    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] data = '0;
    logic [1:0]  en = '0;
    logic        req = 1'b0;
    logic [1:0]  so_a;
    logic [1:0]  so_b;
    logic        ta_a;
    logic        ta_b;
    logic        lk_a;
    logic        lk_b;

    int ratio = 5;
    int sc = 0;
    int ncmp = 0;
    int nerr = 0;

    lvds_tx_lanes_param #(
        .LANES(2), .DATA_W(10), .MSB_FIRST(1), .TRAIN_LEN(16)
    ) dut_a (
        .I_pixel_clk   (pclk),
        .I_serial_clk  (sclk),
        .I_rst         (rst),
        .I_data_in     (data),
        .I_lane_en     (en),
        .I_train_req   (req),
        .O_serial_out  (so_a),
        .O_train_active(ta_a),
        .O_locked      (lk_a)
    );

    lvds_tx_lanes_param #(
        .LANES(2), .DATA_W(10), .MSB_FIRST(0), .TRAIN_LEN(16)
    ) dut_b (
        .I_pixel_clk   (pclk),
        .I_serial_clk  (sclk),
        .I_rst         (rst),
        .I_data_in     (data),
        .I_lane_en     (en),
        .I_train_req   (req),
        .O_serial_out  (so_b),
        .O_train_active(ta_b),
        .O_locked      (lk_b)
    );

    // Pixel rising edges coincide with serial rising edges.
    initial begin
        forever begin
            int r;
            r = ratio;
            for (int ph = 0; ph < r; ph++) begin
                sc++;
                sclk = 1'b1;
                if (ph == 0) pclk = 1'b1;
                #5;
                sclk = 1'b0;
                if (ph == 2) pclk = 1'b0;
                #5;
            end
        end
    end

    typedef struct {
        int          sc;
        logic [19:0] w;
        bit          valid;
    } ent_t;

    ent_t exq[$];
    int   last_sc = -100;
    int   stable = 0;
    int   train_left = 0;
    bit   zero_next = 1'b1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Word model: one expected word per pixel edge, plus training length.
    always @(posedge pclk) begin
        ent_t e;
        stable = (sc - last_sc == 5) ? stable + 1 : 0;
        last_sc = sc;
        e.sc = sc;
        e.valid = (stable >= 1);
        e.w = '0;
        if (rst) begin
            zero_next = 1'b1;
            train_left = 0;
        end else begin
            if (!zero_next) begin
                for (int k = 0; k < 2; k++) begin
                    if (train_left > 0)
                        e.w[k*10 +: 10] = 10'h3E0;
                    else if (en[k])
                        e.w[k*10 +: 10] = data[k*10 +: 10];
                end
            end
            zero_next = 1'b0;
            if (req) train_left = 16;
            else if (train_left > 0) train_left--;
        end
        exq.push_back(e);
        #1;
        chk("train_active_a", 32'(ta_a), 32'(train_left > 0));
        chk("train_active_b", 32'(ta_b), 32'(train_left > 0));
    end

    logic [9:0] rx_a [2];
    logic [9:0] rx_b [2];
    logic [9:0] last_a [2];
    logic [9:0] last_b [2];

    task automatic bitchk(input string name, input int k, input logic act,
                          input logic exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            if (nerr < 30)
                $display("FAIL %s lane%0d @sc%0d: got %b required %b",
                         name, k, sc, act, exp);
        end
    endtask

    always @(posedge sclk) begin
        int c;
        int j;
        logic [1:0] ha, hb, la, lb;
        logic rh, rl, ok;
        c = sc;
        #2;
        ha = so_a; hb = so_b; rh = rst;
        @(negedge sclk);
        #2;
        la = so_a; lb = so_b; rl = rst;
        while (exq.size() > 1 && exq[1].sc + 3 <= c) void'(exq.pop_front());
        ok = exq.size() > 0 && exq[0].sc + 3 <= c && c - exq[0].sc - 3 < 5
             && exq[0].valid;
        j = ok ? c - exq[0].sc - 3 : 0;
        for (int k = 0; k < 2; k++) begin
            if (rh) begin
                bitchk("rst_hi_a", k, ha[k], 1'b0);
                bitchk("rst_hi_b", k, hb[k], 1'b0);
            end else if (ok) begin
                bitchk("hi_a", k, ha[k], exq[0].w[k*10 + 9 - 2*j]);
                bitchk("hi_b", k, hb[k], exq[0].w[k*10 + 2*j]);
            end
            if (rl) begin
                bitchk("rst_lo_a", k, la[k], 1'b0);
                bitchk("rst_lo_b", k, lb[k], 1'b0);
            end else if (ok) begin
                bitchk("lo_a", k, la[k], exq[0].w[k*10 + 8 - 2*j]);
                bitchk("lo_b", k, lb[k], exq[0].w[k*10 + 2*j + 1]);
            end
            rx_a[k] = {rx_a[k][7:0], ha[k], la[k]};
            rx_b[k] = {rx_b[k][7:0], hb[k], lb[k]};
            if (ok && !rh && !rl && j == 4) begin
                last_a[k] = rx_a[k];
                last_b[k] = rx_b[k];
            end
        end
    end

    task automatic pix(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic wait_lock(input logic want, input int bound,
                             input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(posedge pclk);
            #1;
            if (lk_a === want && lk_b === want) hit = 1'b1;
        end
        ncmp++;
        if (!hit) begin
            nerr++;
            $display("FAIL %s: O_locked=%b/%b required %b within %0d cycles",
                     name, lk_a, lk_b, want, bound);
        end
    endtask

    initial begin
        int n;
        logic [9:0] tr_a, tr_b;
        data = {10'h0FF, 10'h2AA};
        en = 2'b11;
        pix(3);
        chk("rst_locked", 32'(lk_a), 32'd0);
        chk("rst_train", 32'(ta_a), 32'd0);
        chk("rst_serial", 32'({so_a, so_b}), 32'd0);
        @(negedge sclk);
        rst = 1'b0;
        wait_lock(1'b1, 8, "lock_after_reset");
        pix(4);
        chk("stream_l0", 32'(last_a[0]), 32'(10'b1010101010));
        chk("stream_l1", 32'(last_a[1]), 32'(10'b0011111111));
        chk("lsb_l0", 32'(last_b[0]), 32'(10'b0101010101));
        chk("lsb_l1", 32'(last_b[1]), 32'(10'b1111111100));

        data[9:0] = 10'h001;
        pix(4);
        chk("lsb_one", 32'(last_b[0]), 32'(10'b1000000000));
        chk("msb_one", 32'(last_a[0]), 32'(10'b0000000001));
        data[9:0] = 10'h2AA;
        pix(3);

        n = 0;
        req = 1'b1;
        @(posedge pclk);
        #1;
        if (ta_a) n++;
        @(negedge pclk);
        req = 1'b0;
        tr_a = '0;
        tr_b = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge pclk);
            #1;
            if (ta_a) n++;
            if (i == 10) begin
                tr_a = last_a[1];
                tr_b = last_b[0];
            end
        end
        chk("train_cycles", 32'(n), 32'd16);
        chk("train_word_a", 32'(tr_a), 32'(10'b1111100000));
        chk("train_word_b", 32'(tr_b), 32'(10'b0000011111));
        chk("resume_l0", 32'(last_a[0]), 32'(10'b1010101010));

        @(negedge pclk);
        en = 2'b01;
        pix(4);
        chk("lane1_off", 32'(last_a[1]), 32'd0);
        chk("lane0_on", 32'(last_a[0]), 32'(10'b1010101010));
        en = 2'b11;
        pix(3);
        chk("lane1_back", 32'(last_a[1]), 32'(10'b0011111111));

        ratio = 6;
        wait_lock(1'b0, 5, "unlock_ratio6");
        pix(3);
        ratio = 5;
        pix(3);
        chk("relock_early", 32'(lk_a), 32'd0);
        wait_lock(1'b1, 12, "relock_ratio5");
        pix(3);

        @(negedge sclk);
        @(negedge sclk);
        rst = 1'b1;
        #1;
        chk("midrst_serial", 32'({so_a, so_b}), 32'd0);
        chk("midrst_locked", 32'(lk_a), 32'd0);
        pix(3);
        @(negedge sclk);
        rst = 1'b0;
        pix(3);
        chk("post_rst_unlocked", 32'(lk_a), 32'd0);
        wait_lock(1'b1, 8, "lock_after_midrst");
        pix(3);
        chk("post_rst_l0", 32'(last_a[0]), 32'(10'b1010101010));
        chk("post_rst_l1", 32'(last_a[1]), 32'(10'b0011111111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
